// File: rtl/i2c_slave_responder_if.sv
// Bus-side signal bundle of the I2C target: the open-drain pins plus the
// byte-level handshake towards the local logic.
interface i2c_slave_responder_if #(
    parameter int DATAWIDTH = 8
);
    logic                 scl;
    logic                 slavesda;
    logic                 sda_oe;
    logic                 ack;
    logic [DATAWIDTH-1:0] rx_data;
    logic                 rx_valid;
    logic [DATAWIDTH-1:0] tx_data;
    logic                 tx_req;
    logic                 busy;

    modport slave (
        input  scl, slavesda, tx_data,
        output sda_oe, ack, rx_data, rx_valid, tx_req, busy
    );

    modport master (
        output scl, slavesda, tx_data,
        input  sda_oe, ack, rx_data, rx_valid, tx_req, busy
    );
endinterface

// File: rtl/i2c_slave_responder.sv
// Single-address I2C target: oversamples SCL/SDA, detects START/STOP,
// ACKs its address, delivers write bytes and serializes read bytes.
module i2c_slave_responder #(
    parameter int                   ADDRWIDTH  = 7,
    parameter int                   DATAWIDTH  = 8,
    parameter logic [ADDRWIDTH-1:0] SLAVE_ADDR = 7'h50
) (
    input logic clk,
    input logic rst,
    i2c_slave_responder_if.slave bus
);
    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_ADDR      = 3'd1;
    localparam logic [2:0] S_ADDR_ACK  = 3'd2;
    localparam logic [2:0] S_WR_DATA   = 3'd3;
    localparam logic [2:0] S_WR_ACK    = 3'd4;
    localparam logic [2:0] S_RD_DATA   = 3'd5;
    localparam logic [2:0] S_RD_ACK    = 3'd6;
    localparam logic [2:0] S_WAIT_STOP = 3'd7;

    localparam logic [3:0] LAST_BIT  = 4'(DATAWIDTH - 1);
    localparam logic [3:0] BYTE_DONE = 4'(DATAWIDTH);

    logic r_scl_p0, r_scl_p1, r_scl_p2;
    logic r_sda_p0, r_sda_p1, r_sda_p2;
    logic r_scl_rise, r_scl_fall, r_start, r_stop;

    logic [2:0]           r_state;
    logic [3:0]           r_cnt;
    logic [DATAWIDTH-1:0] r_shift;
    logic                 r_rw;
    logic                 r_mst_ack;
    logic                 r_sda_oe, r_ack, r_rx_valid, r_tx_req, r_busy;
    logic [DATAWIDTH-1:0] r_rx_data;
    logic [DATAWIDTH-1:0] w_shift_in;

    assign w_shift_in = {r_shift[DATAWIDTH-2:0], r_sda_p1};

    // Stage p0/p1 synchronize, p2 holds the previous level; events are registered
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_scl_p0   <= 1'b1;
            r_scl_p1   <= 1'b1;
            r_scl_p2   <= 1'b1;
            r_sda_p0   <= 1'b1;
            r_sda_p1   <= 1'b1;
            r_sda_p2   <= 1'b1;
            r_scl_rise <= 1'b0;
            r_scl_fall <= 1'b0;
            r_start    <= 1'b0;
            r_stop     <= 1'b0;
        end else begin
            r_scl_p0   <= bus.scl;
            r_scl_p1   <= r_scl_p0;
            r_scl_p2   <= r_scl_p1;
            r_sda_p0   <= bus.slavesda;
            r_sda_p1   <= r_sda_p0;
            r_sda_p2   <= r_sda_p1;
            r_scl_rise <= r_scl_p1 & ~r_scl_p2;
            r_scl_fall <= ~r_scl_p1 & r_scl_p2;
            r_start    <= r_scl_p1 & r_scl_p2 & ~r_sda_p1 & r_sda_p2;
            r_stop     <= r_scl_p1 & r_scl_p2 & r_sda_p1 & ~r_sda_p2;
        end
    end

    // Protocol FSM; START/STOP override any SCL edge seen in the same cycle
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= S_IDLE;
            r_cnt      <= 4'd0;
            r_shift    <= '0;
            r_rw       <= 1'b0;
            r_mst_ack  <= 1'b0;
            r_sda_oe   <= 1'b0;
            r_ack      <= 1'b0;
            r_rx_data  <= '0;
            r_rx_valid <= 1'b0;
            r_tx_req   <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            r_ack      <= 1'b0;
            r_rx_valid <= 1'b0;
            r_tx_req   <= 1'b0;
            if (r_start) begin
                r_state  <= S_ADDR;
                r_cnt    <= 4'd0;
                r_sda_oe <= 1'b0;
                r_busy   <= 1'b0;
            end else if (r_stop) begin
                r_state  <= S_IDLE;
                r_cnt    <= 4'd0;
                r_sda_oe <= 1'b0;
                r_busy   <= 1'b0;
            end else begin
                case (r_state)
                    S_ADDR: begin
                        if (r_scl_rise && r_cnt != BYTE_DONE) begin
                            r_shift <= w_shift_in;
                            r_cnt   <= r_cnt + 4'd1;
                        end else if (r_scl_fall && r_cnt == BYTE_DONE) begin
                            if (r_shift[DATAWIDTH-1:1] == SLAVE_ADDR) begin
                                r_state  <= S_ADDR_ACK;
                                r_sda_oe <= 1'b1;
                                r_ack    <= 1'b1;
                                r_busy   <= 1'b1;
                                r_rw     <= r_shift[0];
                            end else begin
                                r_state  <= S_WAIT_STOP;
                                r_sda_oe <= 1'b0;
                            end
                        end
                    end
                    S_ADDR_ACK: begin
                        if (r_scl_fall) begin
                            r_cnt <= 4'd0;
                            if (r_rw) begin
                                r_shift  <= bus.tx_data;
                                r_tx_req <= 1'b1;
                                r_sda_oe <= ~bus.tx_data[DATAWIDTH-1];
                                r_state  <= S_RD_DATA;
                            end else begin
                                r_sda_oe <= 1'b0;
                                r_state  <= S_WR_DATA;
                            end
                        end
                    end
                    S_WR_DATA: begin
                        if (r_scl_rise && r_cnt != BYTE_DONE) begin
                            r_shift <= w_shift_in;
                            r_cnt   <= r_cnt + 4'd1;
                            if (r_cnt == LAST_BIT) begin
                                r_rx_data  <= w_shift_in;
                                r_rx_valid <= 1'b1;
                            end
                        end else if (r_scl_fall && r_cnt == BYTE_DONE) begin
                            r_state  <= S_WR_ACK;
                            r_sda_oe <= 1'b1;
                            r_ack    <= 1'b1;
                        end
                    end
                    S_WR_ACK: begin
                        if (r_scl_fall) begin
                            r_sda_oe <= 1'b0;
                            r_cnt    <= 4'd0;
                            r_state  <= S_WR_DATA;
                        end
                    end
                    S_RD_DATA: begin
                        if (r_scl_fall) begin
                            if (r_cnt == LAST_BIT) begin
                                r_sda_oe  <= 1'b0;
                                r_cnt     <= 4'd0;
                                r_mst_ack <= 1'b0;
                                r_state   <= S_RD_ACK;
                            end else begin
                                r_shift  <= {r_shift[DATAWIDTH-2:0], 1'b0};
                                r_sda_oe <= ~r_shift[DATAWIDTH-2];
                                r_cnt    <= r_cnt + 4'd1;
                            end
                        end
                    end
                    S_RD_ACK: begin
                        if (r_scl_rise) begin
                            if (r_sda_p1) begin
                                r_state <= S_WAIT_STOP;
                                r_busy  <= 1'b0;
                            end else begin
                                r_mst_ack <= 1'b1;
                            end
                        end else if (r_scl_fall && r_mst_ack) begin
                            r_shift  <= bus.tx_data;
                            r_tx_req <= 1'b1;
                            r_sda_oe <= ~bus.tx_data[DATAWIDTH-1];
                            r_cnt    <= 4'd0;
                            r_state  <= S_RD_DATA;
                        end
                    end
                    default: r_sda_oe <= 1'b0;
                endcase
            end
        end
    end

    assign bus.sda_oe   = r_sda_oe;
    assign bus.ack      = r_ack;
    assign bus.rx_data  = r_rx_data;
    assign bus.rx_valid = r_rx_valid;
    assign bus.tx_req   = r_tx_req;
    assign bus.busy     = r_busy;

endmodule

// File: tb/tb_i2c_slave_responder.sv
// Directed bench for i2c_slave_responder: a bit-banged I2C master with an
// open-drain line model, a table of single-byte transactions and corner sequences.
module tb_i2c_slave_responder;
    localparam int Q = 5;

    typedef struct {
        logic [7:0] addr_b;
        logic [7:0] data;
        logic       alvl;
        logic       dlvl;
        int         acks;
        int         rxv;
        int         txr;
        logic [7:0] byte_e;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    logic m_sda;

    i2c_slave_responder_if bus();
    assign bus.slavesda = m_sda & ~bus.sda_oe;

    i2c_slave_responder dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int n_ack  = 0;
    int n_rxv  = 0;
    int n_txr  = 0;
    logic [7:0] rx_q[$];

    always @(negedge clk) begin
        if (bus.ack) n_ack++;
        if (bus.tx_req) n_txr++;
        if (bus.rx_valid) begin
            n_rxv++;
            rx_q.push_back(bus.rx_data);
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic qwait();
        repeat (Q) @(negedge clk);
    endtask

    task automatic sbit(input logic b, output logic line, output logic oe);
        m_sda = b;
        qwait();
        bus.scl = 1'b1;
        qwait();
        line = bus.slavesda;
        oe   = bus.sda_oe;
        qwait();
        bus.scl = 1'b0;
        qwait();
    endtask

    task automatic start_c();
        m_sda = 1'b1;
        qwait();
        bus.scl = 1'b1;
        qwait();
        m_sda = 1'b0;
        qwait();
        bus.scl = 1'b0;
        qwait();
    endtask

    task automatic stop_c();
        m_sda = 1'b0;
        qwait();
        bus.scl = 1'b1;
        qwait();
        m_sda = 1'b1;
        qwait();
    endtask

    task automatic send_bits(input logic [7:0] d, input int n);
        logic l, o;
        for (int i = 0; i < n; i++) sbit(d[7-i], l, o);
    endtask

    task automatic send_byte(input logic [7:0] d, output logic ackl, output logic acko);
        send_bits(d, 8);
        sbit(1'b1, ackl, acko);
    endtask

    task automatic recv8(output logic [7:0] d, output logic [7:0] pat);
        for (int i = 7; i >= 0; i--) sbit(1'b1, d[i], pat[i]);
    endtask

    initial begin
        vec_t vt[9];
        logic l, o;
        logic [7:0] rd, rd2, pat, pat2, inv;
        int a0, r0, t0, q0;

        vt[0] = '{8'hA0, 8'h3C, 1'b0, 1'b0, 2, 1, 0, 8'h3C};
        vt[1] = '{8'hA2, 8'h55, 1'b1, 1'b1, 0, 0, 0, 8'h3C};
        vt[2] = '{8'hA0, 8'h00, 1'b0, 1'b0, 2, 1, 0, 8'h00};
        vt[3] = '{8'hA0, 8'hFF, 1'b0, 1'b0, 2, 1, 0, 8'hFF};
        vt[4] = '{8'hA1, 8'h96, 1'b0, 1'b1, 1, 0, 1, 8'h96};
        vt[5] = '{8'hA3, 8'h96, 1'b1, 1'b1, 0, 0, 0, 8'hFF};
        vt[6] = '{8'hAE, 8'h12, 1'b1, 1'b1, 0, 0, 0, 8'hFF};
        vt[7] = '{8'hA1, 8'h00, 1'b0, 1'b1, 1, 0, 1, 8'h00};
        vt[8] = '{8'hA1, 8'h80, 1'b0, 1'b1, 1, 0, 1, 8'h80};

        rst = 1'b0;
        bus.scl = 1'b1;
        m_sda = 1'b1;
        bus.tx_data = 8'h00;
        repeat (3) @(negedge clk);
        check("reset sda_oe", bus.sda_oe, 1'b0);
        check("reset outputs", {bus.ack, bus.rx_valid, bus.tx_req, bus.busy, bus.rx_data}, 12'h000);
        rst = 1'b1;
        repeat (4) @(negedge clk);

        for (int k = 0; k < 9; k++) begin
            a0 = n_ack; r0 = n_rxv; t0 = n_txr;
            bus.tx_data = vt[k].data;
            start_c();
            send_byte(vt[k].addr_b, l, o);
            check($sformatf("v%0d addr ack line", k), l, vt[k].alvl);
            if (!vt[k].addr_b[0]) begin
                send_byte(vt[k].data, l, o);
                check($sformatf("v%0d data ack line", k), l, vt[k].dlvl);
                check($sformatf("v%0d rx_data", k), bus.rx_data, vt[k].byte_e);
            end else begin
                recv8(rd, pat);
                sbit(1'b1, l, o);
                inv = ~vt[k].byte_e;
                check($sformatf("v%0d read byte", k), rd, vt[k].byte_e);
                check($sformatf("v%0d sda_oe pattern", k), pat, inv);
            end
            stop_c();
            qwait();
            check($sformatf("v%0d ack pulses", k), n_ack - a0, vt[k].acks);
            check($sformatf("v%0d rx_valid pulses", k), n_rxv - r0, vt[k].rxv);
            check($sformatf("v%0d tx_req pulses", k), n_txr - t0, vt[k].txr);
            check($sformatf("v%0d busy after stop", k), bus.busy, 1'b0);
        end

        // Two-byte write
        a0 = n_ack; r0 = n_rxv; q0 = rx_q.size();
        start_c();
        send_byte(8'hA0, l, o);
        check("wr2 addr ack oe", o, 1'b1);
        check("wr2 busy", bus.busy, 1'b1);
        send_byte(8'h3C, l, o);
        check("wr2 byte1 ack oe", o, 1'b1);
        send_byte(8'hC3, l, o);
        check("wr2 byte2 ack oe", o, 1'b1);
        stop_c();
        qwait();
        check("wr2 ack pulses", n_ack - a0, 3);
        check("wr2 rx_valid pulses", n_rxv - r0, 2);
        if (rx_q.size() >= q0 + 2) begin
            check("wr2 first rx", rx_q[q0], 8'h3C);
            check("wr2 second rx", rx_q[q0+1], 8'hC3);
        end
        check("wr2 busy end", bus.busy, 1'b0);

        // Read with NACK, extra clocks in WAIT_STOP
        a0 = n_ack; t0 = n_txr;
        bus.tx_data = 8'h96;
        start_c();
        send_byte(8'hA1, l, o);
        check("rdn tx_req after addr", n_txr - t0, 1);
        recv8(rd, pat);
        check("rdn read", rd, 8'h96);
        check("rdn oe pattern", pat, 8'h69);
        sbit(1'b1, l, o);
        check("rdn busy after nack", bus.busy, 1'b0);
        sbit(1'b1, l, o);
        sbit(1'b1, l, o);
        stop_c();
        qwait();
        check("rdn tx_req total", n_txr - t0, 1);
        check("rdn ack pulses", n_ack - a0, 1);

        // Two-byte read, ACK then NACK
        t0 = n_txr;
        bus.tx_data = 8'h5A;
        start_c();
        send_byte(8'hA1, l, o);
        recv8(rd, pat);
        bus.tx_data = 8'hFF;
        sbit(1'b0, l, o);
        recv8(rd2, pat2);
        sbit(1'b1, l, o);
        stop_c();
        qwait();
        check("rd2 byte1", rd, 8'h5A);
        check("rd2 byte2", rd2, 8'hFF);
        check("rd2 byte2 oe", pat2, 8'h00);
        check("rd2 tx_req pulses", n_txr - t0, 2);

        // Repeated START in the middle of a write byte
        a0 = n_ack; r0 = n_rxv; t0 = n_txr;
        start_c();
        send_byte(8'hA0, l, o);
        send_bits(8'hF0, 4);
        bus.tx_data = 8'h3C;
        start_c();
        send_byte(8'hA1, l, o);
        check("rs readdr ack line", l, 1'b0);
        recv8(rd, pat);
        sbit(1'b1, l, o);
        stop_c();
        qwait();
        check("rs rx_valid pulses", n_rxv - r0, 0);
        check("rs ack pulses", n_ack - a0, 2);
        check("rs tx_req pulses", n_txr - t0, 1);
        check("rs read", rd, 8'h3C);

        // Asynchronous reset while ACKing a write byte
        start_c();
        send_byte(8'hA0, l, o);
        send_bits(8'h77, 8);
        m_sda = 1'b1;
        qwait();
        bus.scl = 1'b1;
        qwait();
        check("rr oe before reset", bus.sda_oe, 1'b1);
        rst = 1'b0;
        #1;
        check("rr oe in reset", bus.sda_oe, 1'b0);
        check("rr outputs in reset", {bus.ack, bus.rx_valid, bus.tx_req, bus.busy, bus.rx_data}, 12'h000);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        bus.scl = 1'b0;
        qwait();
        stop_c();
        a0 = n_ack; r0 = n_rxv;
        start_c();
        send_byte(8'hA0, l, o);
        check("rr addr ack line", l, 1'b0);
        send_byte(8'h11, l, o);
        check("rr data ack line", l, 1'b0);
        stop_c();
        qwait();
        check("rr rx_data", bus.rx_data, 8'h11);
        check("rr ack pulses", n_ack - a0, 2);
        check("rr rx_valid pulses", n_rxv - r0, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/i2c_slave_responder.md
Name: i2c_slave_responder

Overview:
Single-address I2C target (responder) that sits on the slave side of the memorysubsystem bus. It answers transactions issued by the I2C master over scl/sda. It oversamples the open-drain SCL/SDA lines on clk, detects START/STOP, matches the 7-bit address, and ACKs. On writes it delivers received bytes to the local logic; on reads it serializes bytes supplied by the local logic.

Parameters:
ADDRWIDTH, 7, target address width (fixed by protocol; only 7 supported)
DATAWIDTH, 8, byte width (fixed by protocol; only 8 supported)
SLAVE_ADDR, 7'h50, address this target responds to

Ports:
clk  input  1  system clock; must be >= 8x SCL frequency
rst  input  1  asynchronous active-low reset
scl  input  1  I2C clock line, asynchronous to clk
slavesda  input  1  SDA line level as seen at the pin
sda_oe  output  1  1 = pull SDA low; 0 = release (open-drain)
ack  output  1  one-clk pulse when this target ACKs a byte (address or write data)
rx_data  output  DATAWIDTH  last write byte received
rx_valid  output  1  one-clk pulse; rx_data updated this cycle
tx_data  input  DATAWIDTH  byte to return on read
tx_req  output  1  one-clk pulse; tx_data sampled this cycle, next byte may be presented
busy  output  1  1 from matched address ACK until STOP/START/NACK

Behaviour:
- Reset (rst=0, async): state=IDLE, sda_oe=0, ack=0, rx_data=0, rx_valid=0, tx_req=0, busy=0, bit counter=0, shift register=0. The synchronizers also reset to 1.
- Input conditioning: scl and slavesda each pass through a 2-flop synchronizer, then a previous-value register.
- Edge events: scl_rise, scl_fall. START = sda falls while scl high. STOP = sda rises while scl high.
- Event latency: each event is a one-clk pulse, 3 clk after the pin transition. sda_oe updates in the cycle after the triggering event.
- Sampling and driving: SDA is sampled only on scl_rise. sda_oe changes only on scl_fall, except on START/STOP/reset, which release it immediately.
- IDLE: waits for START, then goes to ADDR with counter=0.
- ADDR: shift in 8 bits MSB first on scl_rise.
  - After the 8th bit, compare bits[7:1] against SLAVE_ADDR.
  - Match: next scl_fall -> ADDR_ACK with sda_oe=1, ack pulse, busy=1.
  - Mismatch: WAIT_STOP with sda_oe=0.
- ADDR_ACK: on scl_fall, release the ACK.
  - R/W=0: go to WR_DATA.
  - R/W=1: load shifter from tx_data, pulse tx_req, drive sda_oe=~MSB, go to RD_DATA.
- WR_DATA: shift in 8 bits on scl_rise. On the 8th, rx_data<=shifter (written 1 clk after scl_rise), rx_valid pulses 1 clk. Next scl_fall -> WR_ACK with sda_oe=1, ack pulse.
- WR_ACK: on scl_fall, release and return to WR_DATA with counter=0. Byte count is unlimited.
- RD_DATA: on each scl_fall after bits 0..6, drive sda_oe=~next bit. After the 8th bit's scl_fall, sda_oe=0 and go to RD_ACK.
- RD_ACK: sample the master's bit on scl_rise.
  - 0 (ACK): on next scl_fall, load tx_data, pulse tx_req, drive MSB, return to RD_DATA.
  - 1 (NACK): WAIT_STOP, busy=0.
- WAIT_STOP: sda_oe=0. Ignore everything except START/STOP.
- START in any state (repeated start) -> ADDR, counter=0, sda_oe=0, busy=0. A partial byte is discarded: no rx_valid.
- STOP in any state -> IDLE, sda_oe=0, busy=0. A partial byte is discarded.
- Simultaneous events: START/STOP take priority over scl edges. scl_rise and scl_fall cannot coincide.
- Clock stretching: not supported. sda_oe never drives scl.
- Never sample tx_data except on the cycle tx_req is high.

Test Plan:
- Write two bytes: SLAVE_ADDR=7'h50; START, 0xA0, 0x3C, 0xC3, STOP -> sda_oe=1 during all 3 ACK bits, ack pulses 3x, rx_valid pulses 2x with rx_data 0x3C then 0xC3, busy ends 0 in IDLE.
- Address mismatch: START, 0xA2, 0x55, STOP -> sda_oe stays 0 throughout, no ack/rx_valid, busy=0.
- Read with NACK: START, 0xA1, tx_data=0x96, master NACK, STOP -> tx_req pulses once at end of address ACK. sda_oe over 8 bits = 0,1,1,0,1,0,0,1 (inverse of 1001_0110). Then WAIT_STOP, and a second tx_req must not occur.
- Read two bytes with ACK: tx_data 0x5A then 0xFF, master ACKs byte 1 and NACKs byte 2 -> tx_req pulses 2x, second byte leaves sda_oe=0 for all 8 bits.
- Repeated start mid-byte: START, 0xA0, 4 bits of 0xF0, START, 0xA1 -> no rx_valid, address re-ACKed, read begins.
- Reset mid-transfer: assert rst while sda_oe=1 in WR_ACK -> sda_oe=0 immediately (async), all outputs 0. A following full write of 0xA0, 0x11 is ACKed and delivers rx_data=0x11.
